// File: rtl/rt_pkg.sv
// Shared ray-tracing types: fixed-point vectors, ray packing, generator
// state encoding and the signed-overflow helper used by the adders.
package rt_pkg;

    localparam int RT_W       = 32;
    localparam int RAY_ORIGIN = 1;
    localparam int RAY_DIR    = 0;

    typedef logic signed [RT_W-1:0] coord_t;
    typedef coord_t [2:0]           vec3_t;
    typedef vec3_t  [1:0]           ray_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/ray_gen_if.sv
// Camera-config / ray-stream bundle between the generator and its neighbours.
// master = ray generator, slave = the surrounding config + consumer side.
interface ray_gen_if import rt_pkg::*; #(
    parameter int W  = RT_W,
    parameter int XW = 12,
    parameter int YW = 12
);
    logic                     i_start;
    logic [XW-1:0]            i_width;
    logic [YW-1:0]            i_height;
    logic [2:0][W-1:0]        i_eye;
    logic [2:0][W-1:0]        i_dir00;
    logic [2:0][W-1:0]        i_du;
    logic [2:0][W-1:0]        i_dv;
    logic [1:0][2:0][W-1:0]   o_ray;
    logic                     o_valid;
    logic                     i_ready;
    logic [XW-1:0]            o_px_x;
    logic [YW-1:0]            o_px_y;
    logic                     o_last;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_overflow;

    modport master (
        input  i_start, i_width, i_height, i_eye, i_dir00, i_du, i_dv, i_ready,
        output o_ray, o_valid, o_px_x, o_px_y, o_last, o_busy, o_done, o_overflow
    );

    modport slave (
        output i_start, i_width, i_height, i_eye, i_dir00, i_du, i_dv, i_ready,
        input  o_ray, o_valid, o_px_x, o_px_y, o_last, o_busy, o_done, o_overflow
    );
endinterface

// File: rtl/ray_gen_vec3_add_ovf.sv
// Combinational 3-component wrapped signed add; ovf is the OR of the
// per-component signed overflows.
module vec3_add_ovf import rt_pkg::*; #(
    parameter int W = RT_W
) (
    input  logic [2:0][W-1:0] a,
    input  logic [2:0][W-1:0] b,
    output logic [2:0][W-1:0] sum,
    output logic              ovf
);

    // Per-component add with wrap, accumulating any overflow.
    always_comb begin
        sum = '0;
        ovf = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sum[c] = a[c] + b[c];
            ovf    = ovf | add_ovf(a[c][W-1], b[c][W-1], sum[c][W-1]);
        end
    end

endmodule

// File: rtl/ray_gen.sv
// Raster-scan ray source. Emits one ray per pixel (origin = eye, direction
// stepped incrementally by du along a row and dv between rows) over a
// valid/ready stream, then pulses o_done for one cycle.
module ray_gen import rt_pkg::*; #(
    parameter int W  = RT_W,
    parameter int XW = 12,
    parameter int YW = 12
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    ray_gen_if.master bus
);

    state_t            state_r;
    state_t            state_s;
    logic [XW-1:0]     width_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     height_r;
    logic [YW-1:0]     y_r;
    logic [2:0][W-1:0] eye_r;
    logic [2:0][W-1:0] dir_r;
    logic [2:0][W-1:0] row_base_r;
    logic [2:0][W-1:0] du_r;
    logic [2:0][W-1:0] dv_r;
    logic [2:0][W-1:0] du_sum_s;
    logic [2:0][W-1:0] dv_sum_s;
    logic              du_ovf_s;
    logic              dv_ovf_s;
    logic              ovf_r;
    logic              load_s;
    logic              run_s;
    logic              xfer_s;
    logic              end_row_s;
    logic              last_row_s;

    assign run_s      = (state_r == RUN);
    assign xfer_s     = run_s && bus.i_ready;
    assign end_row_s  = (x_r == (width_r - XW'(1)));
    assign last_row_s = (y_r == (height_r - YW'(1)));

    // Next direction along the row, and first direction of the next row.
    vec3_add_ovf #(.W(W)) u_du_add (
        .a   (dir_r),
        .b   (du_r),
        .sum (du_sum_s),
        .ovf (du_ovf_s)
    );

    vec3_add_ovf #(.W(W)) u_dv_add (
        .a   (row_base_r),
        .b   (dv_r),
        .sum (dv_sum_s),
        .ovf (dv_ovf_s)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; load_s marks a start that opens a non-empty frame.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_start) begin
                    if ((bus.i_width != {XW{1'b0}}) && (bus.i_height != {YW{1'b0}})) begin
                        state_s = RUN;
                        load_s  = 1'b1;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (xfer_s && end_row_s && last_row_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Frame datapath: latch config at start, step pixel and direction on transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            width_r    <= {XW{1'b0}};
            height_r   <= {YW{1'b0}};
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            eye_r      <= '0;
            dir_r      <= '0;
            row_base_r <= '0;
            du_r       <= '0;
            dv_r       <= '0;
            ovf_r      <= 1'b0;
        end else if (load_s) begin
            width_r    <= bus.i_width;
            height_r   <= bus.i_height;
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            eye_r      <= bus.i_eye;
            dir_r      <= bus.i_dir00;
            row_base_r <= bus.i_dir00;
            du_r       <= bus.i_du;
            dv_r       <= bus.i_dv;
            ovf_r      <= 1'b0;
        end else if (xfer_s) begin
            if (!end_row_s) begin
                dir_r <= du_sum_s;
                x_r   <= x_r + XW'(1);
                ovf_r <= ovf_r | du_ovf_s;
            end else if (!last_row_s) begin
                row_base_r <= dv_sum_s;
                dir_r      <= dv_sum_s;
                x_r        <= {XW{1'b0}};
                y_r        <= y_r + YW'(1);
                ovf_r      <= ovf_r | dv_ovf_s;
            end else begin
                // Last pixel accepted: counters hold, FSM moves to DONE.
                x_r <= x_r;
            end
        end else begin
            x_r <= x_r;
        end
    end

    // Ray packing puts origin in the upper slot ([1]) and direction in [0].
    assign bus.o_ray      = {eye_r, dir_r};
    assign bus.o_valid    = run_s;
    assign bus.o_busy     = run_s;
    assign bus.o_done     = (state_r == DONE);
    assign bus.o_last     = run_s && end_row_s && last_row_s;
    assign bus.o_px_x     = x_r;
    assign bus.o_px_y     = y_r;
    assign bus.o_overflow = ovf_r;

endmodule

// File: tb/tb_ray_gen.sv
// Directed self-checking bench for ray_gen.
module tb_ray_gen;
    localparam int W  = 32;
    localparam int XW = 12;
    localparam int YW = 12;

    typedef logic [2:0][W-1:0] v3_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    ray_gen_if #(.W(W), .XW(XW), .YW(YW)) bus ();

    ray_gen #(.W(W), .XW(XW), .YW(YW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic v3_t mk(input int x, input int y, input int z);
        v3_t r;
        r[0] = x;
        r[1] = y;
        r[2] = z;
        return r;
    endfunction

    // Reference direction for pixel (px,py), computed directly by multiply.
    function automatic v3_t model_dir(input v3_t d0, input v3_t du, input v3_t dv, input int px, input int py);
        v3_t r;
        for (int c = 0; c < 3; c++) r[c] = d0[c] + du[c] * W'(px) + dv[c] * W'(py);
        return r;
    endfunction

    // One-cycle start pulse, then scramble the config inputs.
    task automatic drive_start(input int w, input int h, input v3_t eye, input v3_t d0, input v3_t du, input v3_t dv);
        bus.i_width  = w[XW-1:0];
        bus.i_height = h[YW-1:0];
        bus.i_eye    = eye;
        bus.i_dir00  = d0;
        bus.i_du     = du;
        bus.i_dv     = dv;
        bus.i_start  = 1'b1;
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
        bus.i_width  = 12'd5;
        bus.i_height = 12'd5;
        bus.i_eye    = mk(7, 7, 7);
        bus.i_dir00  = mk(-1, -1, -1);
        bus.i_du     = mk(1000, 1000, 1000);
        bus.i_dv     = mk(1000, 1000, 1000);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_done, bus.o_last, bus.o_overflow} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {bus.o_valid, bus.o_busy, bus.o_done, bus.o_last, bus.o_overflow});
        else n_pass++;
        n_checks++;
        if ({bus.o_px_x, bus.o_px_y} !== 24'd0 || bus.o_ray !== '0)
            $display("FAIL reset_data: px=%0d,%0d ray=%h want 0", bus.o_px_x, bus.o_px_y, bus.o_ray);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        v3_t eye = mk(0, 0, 0);
        v3_t d0  = mk(0, 0, -256);
        v3_t du  = mk(16, 0, 0);
        v3_t dv  = mk(0, 16, 0);
        v3_t exp_tab [4];
        exp_tab[0] = mk(0, 0, -256);
        exp_tab[1] = mk(16, 0, -256);
        exp_tab[2] = mk(0, 16, -256);
        exp_tab[3] = mk(16, 16, -256);
        bus.i_ready = 1'b1;
        drive_start(2, 2, eye, d0, du, dv);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({bus.o_valid, bus.o_busy, bus.o_px_x, bus.o_px_y, bus.o_last, bus.o_overflow} !== {1'b1, 1'b1, XW'(k % 2), YW'(k / 2), (k == 3), 1'b0})
                $display("FAIL basic_ctl[%0d]: got v=%b b=%b x=%0d y=%0d last=%b ovf=%b", k, bus.o_valid, bus.o_busy, bus.o_px_x, bus.o_px_y, bus.o_last, bus.o_overflow);
            else n_pass++;
            n_checks++;
            if (bus.o_ray[0] !== exp_tab[k] || bus.o_ray[1] !== eye)
                $display("FAIL basic_ray[%0d]: got %h want %h", k, bus.o_ray, {eye, exp_tab[k]});
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if ({bus.o_done, bus.o_valid, bus.o_busy, bus.o_overflow} !== 4'b1000)
            $display("FAIL basic_done: got done/valid/busy/ovf=%b want 1000", {bus.o_done, bus.o_valid, bus.o_busy, bus.o_overflow});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.o_done, bus.o_valid} !== 2'b00)
            $display("FAIL basic_idle: got done/valid=%b want 00", {bus.o_done, bus.o_valid});
        else n_pass++;
    endtask

    task automatic test_stall();
        v3_t eye = mk(0, 0, 0);
        v3_t d0  = mk(0, 0, -256);
        v3_t du  = mk(16, 0, 0);
        v3_t dv  = mk(0, 16, 0);
        logic [3:0] pat = 4'b1001;
        int   k = 0;
        bit   done_seen = 1'b0;
        drive_start(2, 2, eye, d0, du, dv);
        for (int t = 0; t < 40 && !done_seen; t++) begin
            bus.i_ready = pat[t % 4];
            if (k < 4) begin
                n_checks++;
                if (bus.o_valid !== 1'b1 || bus.o_px_x !== XW'(k % 2) || bus.o_px_y !== YW'(k / 2) || bus.o_ray[0] !== model_dir(d0, du, dv, k % 2, k / 2))
                    $display("FAIL stall[t=%0d]: got v=%b x=%0d y=%0d dir=%h want pixel %0d", t, bus.o_valid, bus.o_px_x, bus.o_px_y, bus.o_ray[0], k);
                else n_pass++;
                if (bus.o_valid && bus.i_ready) k++;
            end else begin
                n_checks++;
                if ({bus.o_done, bus.o_valid} !== 2'b10)
                    $display("FAIL stall_done: got done/valid=%b want 10", {bus.o_done, bus.o_valid});
                else n_pass++;
                done_seen = 1'b1;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!done_seen) $display("FAIL stall_timeout: got %0d transfers want 4", k);
        else n_pass++;
        bus.i_ready = 1'b1;
    endtask

    task automatic test_zero();
        drive_start(0, 5, mk(1, 1, 1), mk(1, 1, 1), mk(1, 1, 1), mk(1, 1, 1));
        n_checks++;
        if ({bus.o_done, bus.o_valid, bus.o_busy} !== 3'b100)
            $display("FAIL zero_done: got done/valid/busy=%b want 100", {bus.o_done, bus.o_valid, bus.o_busy});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.o_done, bus.o_valid, bus.o_busy} !== 3'b000)
            $display("FAIL zero_idle: got done/valid/busy=%b want 000", {bus.o_done, bus.o_valid, bus.o_busy});
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit done_seen = 1'b0;
        bus.i_ready = 1'b1;
        drive_start(2, 1, mk(0, 0, 0), mk(32'h7FFF_FFF0, 0, 0), mk(32'h20, 0, 0), mk(0, 0, 0));
        n_checks++;
        if (bus.o_ray[0][0] !== 32'h7FFF_FFF0 || bus.o_overflow !== 1'b0)
            $display("FAIL ovf_ray0: got x=%h ovf=%b want 7ffffff0 0", bus.o_ray[0][0], bus.o_overflow);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_ray[0][0] !== 32'h8000_0010 || bus.o_overflow !== 1'b1 || bus.o_last !== 1'b1)
            $display("FAIL ovf_ray1: got x=%h ovf=%b last=%b want 80000010 1 1", bus.o_ray[0][0], bus.o_overflow, bus.o_last);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.o_done, bus.o_overflow} !== 2'b11)
            $display("FAIL ovf_done: got done/ovf=%b want 11", {bus.o_done, bus.o_overflow});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow);
        else n_pass++;
        drive_start(2, 2, mk(0, 0, 0), mk(0, 0, -256), mk(16, 0, 0), mk(0, 16, 0));
        n_checks++;
        if ({bus.o_valid, bus.o_overflow} !== 2'b10)
            $display("FAIL ovf_clear: got valid/ovf=%b want 10", {bus.o_valid, bus.o_overflow});
        else n_pass++;
        for (int t = 0; t < 10 && !done_seen; t++) begin
            if (bus.o_done) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!done_seen) $display("FAIL ovf_frame2_timeout: got no done want done");
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        v3_t eye = mk(3, -4, 5);
        v3_t d0  = mk(0, 0, -256);
        v3_t du  = mk(16, 0, 0);
        v3_t dv  = mk(0, 16, 0);
        bus.i_ready = 1'b1;
        drive_start(2, 2, eye, d0, du, dv);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.o_valid !== 1'b1 || bus.o_px_x !== XW'(k % 2) || bus.o_px_y !== YW'(k / 2) || bus.o_ray !== {eye, model_dir(d0, du, dv, k % 2, k / 2)})
                $display("FAIL midstart[%0d]: got v=%b x=%0d y=%0d ray=%h", k, bus.o_valid, bus.o_px_x, bus.o_px_y, bus.o_ray);
            else n_pass++;
            bus.i_start = (k == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        bus.i_start = 1'b0;
        n_checks++;
        if (bus.o_done !== 1'b1) $display("FAIL midstart_done: got %b want 1", bus.o_done);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_valid !== 1'b0) $display("FAIL midstart_idle: got valid %b want 0", bus.o_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        v3_t eye = mk(1, 2, 3);
        v3_t d0  = mk(100, -50, -256);
        v3_t du  = mk(8, 0, 1);
        v3_t dv  = mk(0, 8, 0);
        bit  done_seen = 1'b0;
        bus.i_ready = 1'b1;
        drive_start(3, 2, eye, d0, du, dv);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.o_px_x !== XW'(k) || bus.o_px_y !== YW'(0) || bus.o_ray[0] !== model_dir(d0, du, dv, k, 0))
                $display("FAIL rstmid_pre[%0d]: got x=%0d y=%0d dir=%h", k, bus.o_px_x, bus.o_px_y, bus.o_ray[0]);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_done, bus.o_last, bus.o_overflow} !== 5'b0 || bus.o_ray !== '0 || {bus.o_px_x, bus.o_px_y} !== 24'd0)
            $display("FAIL rstmid_clear: got flags=%b px=%0d,%0d ray=%h want all 0", {bus.o_valid, bus.o_busy, bus.o_done, bus.o_last, bus.o_overflow}, bus.o_px_x, bus.o_px_y, bus.o_ray);
        else n_pass++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_valid !== 1'b0) $display("FAIL rstmid_noreplay: got valid %b want 0", bus.o_valid);
        else n_pass++;
        drive_start(3, 2, eye, d0, du, dv);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (bus.o_valid !== 1'b1 || bus.o_px_x !== XW'(k % 3) || bus.o_px_y !== YW'(k / 3) || bus.o_ray !== {eye, model_dir(d0, du, dv, k % 3, k / 3)} || bus.o_last !== (k == 5))
                $display("FAIL rstmid_post[%0d]: got v=%b x=%0d y=%0d last=%b ray=%h", k, bus.o_valid, bus.o_px_x, bus.o_px_y, bus.o_last, bus.o_ray);
            else n_pass++;
            @(posedge clk); #1;
        end
        done_seen = bus.o_done;
        n_checks++;
        if (!done_seen) $display("FAIL rstmid_done: got %b want 1", bus.o_done);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.i_start  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_width  = 12'd0;
        bus.i_height = 12'd0;
        bus.i_eye    = '0;
        bus.i_dir00  = '0;
        bus.i_du     = '0;
        bus.i_dv     = '0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
